// File: rtl/mem_stage_if.sv
// Data-bus interface between the MEM stage and the data memory.
// Request/grant/response handshake with at most one access outstanding.
interface mem_stage_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: registers the EX bundle, performs one
// load/store over the data bus, stalls IF..MEM while it is outstanding and
// hands the aligned/extended result to WB.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses
// are suppressed and flagged on mem_addr_err instead of being issued.
module mem_stage #(
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [105:0]       ex_to_mem_bus,
  output logic [69:0]        mem_to_wb_bus,
  output logic               stallreq_for_mem,
  mem_stage_if.master        dbus,
  output logic               mem_addr_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  // Select the addressed byte/half of the returned word and extend it.
  function automatic logic [31:0] load_align(input logic [3:0] op,
                                             input logic [1:0] lo,
                                             input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   r = 32'(b);
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = 32'(h);
      OP_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[0];
      OP_LW, OP_SW:         return lo != 2'd0;
      default:              return 1'b0;
    endcase
  endfunction
`endif

  logic [105:0] ex_bus_p0;
  logic [31:0]  hold_p1;
  state_t       state, state_nxt;
  logic         capture, bubble, addr_err;
  logic         rf_we_out;
  logic [31:0]  rf_wdata;

  wire [31:0] pc         = ex_bus_p0[105:74];
  wire [3:0]  mem_op     = ex_bus_p0[73:70];
  wire        rf_we      = ex_bus_p0[69];
  wire [4:0]  rf_waddr   = ex_bus_p0[68:64];
  wire [31:0] ex_result  = ex_bus_p0[63:32];
  wire [31:0] store_data = ex_bus_p0[31:0];
  wire [3:0]  new_op     = ex_to_mem_bus[73:70];

  assign bubble  = stall[STAGE_IDX] & ~stall[STAGE_IDX+1];
  assign capture = ~stall[STAGE_IDX];

  // Entry register: bubble, capture or hold, in that priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ex_bus_p0 <= '0;
    else if (bubble)  ex_bus_p0 <= '0;
    else if (capture) ex_bus_p0 <= ex_to_mem_bus;
  end

  // Access FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Hold register keeps the load response until the entry moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   hold_p1 <= '0;
    else if (state == WAIT && dbus.data_rvalid) hold_p1 <= dbus.data_rdata;
  end

  // Next state: a new capture restarts the FSM, otherwise follow the handshake.
  always_comb begin
    state_nxt = state;
    if (bubble) begin
      state_nxt = IDLE;
    end else if (capture) begin
      if (is_load(new_op) || is_store(new_op)) begin
        state_nxt = REQ;
`ifdef MEM_ALIGN_CHECK_EN
        if (misaligned(new_op, ex_to_mem_bus[33:32])) state_nxt = DONE;
`endif
      end else begin
        state_nxt = IDLE;
      end
    end else begin
      case (state)
        REQ:     if (dbus.data_gnt)    state_nxt = WAIT;
        WAIT:    if (dbus.data_rvalid) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Request fields are driven only while the request is pending.
  always_comb begin
    dbus.data_req   = 1'b0;
    dbus.data_we    = 1'b0;
    dbus.data_be    = 4'b0000;
    dbus.data_addr  = 32'd0;
    dbus.data_wdata = 32'd0;
    if (state == REQ) begin
      dbus.data_req  = 1'b1;
      dbus.data_addr = {ex_result[31:2], 2'b00};
      case (mem_op)
        OP_SB: begin
          dbus.data_we    = 1'b1;
          dbus.data_be    = 4'b0001 << ex_result[1:0];
          dbus.data_wdata = {4{store_data[7:0]}};
        end
        OP_SH: begin
          dbus.data_we    = 1'b1;
          dbus.data_be    = ex_result[1] ? 4'b1100 : 4'b0011;
          dbus.data_wdata = {2{store_data[15:0]}};
        end
        OP_SW: begin
          dbus.data_we    = 1'b1;
          dbus.data_be    = 4'b1111;
          dbus.data_wdata = store_data;
        end
        default: dbus.data_be = 4'b1111;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err = (state == DONE) && misaligned(mem_op, ex_result[1:0]);
`else
  assign addr_err = 1'b0;
`endif

  assign stallreq_for_mem = (state == REQ) || (state == WAIT);
  assign mem_addr_err     = addr_err;
  assign rf_we_out        = rf_we & ~is_store(mem_op) & ~addr_err;
  assign rf_wdata         = is_load(mem_op) ? load_align(mem_op, ex_result[1:0], hold_p1)
                                            : ex_result;

  // WB sees bubbles while the access is outstanding.
  assign mem_to_wb_bus = stallreq_for_mem ? 70'd0 : {pc, rf_we_out, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads of every width, stores with delayed
// grant, passthrough, later-stage hold/bubble and asynchronous reset.
module tb_mem_stage;
  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall, stall_drv;
  logic [105:0] ex_bus;
  logic [69:0]  wb_bus;
  logic         stallreq;
  logic         addr_err;
  int           n_chk = 0;
  int           n_err = 0;

  mem_stage_if dbus_if ();

  mem_stage #(.STALL_W(6), .STAGE_IDX(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_to_mem_bus    (ex_bus),
    .mem_to_wb_bus    (wb_bus),
    .stallreq_for_mem (stallreq),
    .dbus             (dbus_if.master),
    .mem_addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  // Stall controller: freeze IF..MEM (and WB bit) while MEM requests it.
  assign stall = stallreq ? 6'b011111 : stall_drv;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [105:0] mk(input logic [31:0] pc, input logic [3:0] op,
                                      input logic we, input logic [4:0] wa,
                                      input logic [31:0] res, input logic [31:0] sd);
    return {pc, op, we, wa, res, sd};
  endfunction

  function automatic logic [69:0] wbv(input logic [31:0] pc, input logic we,
                                      input logic [4:0] wa, input logic [31:0] wd);
    return {pc, we, wa, wd};
  endfunction

  // Present one access, hold grant off for gdly cycles, respond next cycle.
  task automatic access(input string tag, input logic [105:0] bus, input int gdly,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [69:0] exp_wb);
    ex_bus = bus;
    @(negedge clk);
    ex_bus = '0;
    for (int i = 0; i < gdly; i++) begin
      chk({tag, ".req_held"}, 70'(dbus_if.data_req), 70'd1);
      chk({tag, ".wb_bubble"}, wb_bus, 70'd0);
      @(negedge clk);
    end
    chk({tag, ".req"},      70'(dbus_if.data_req), 70'd1);
    chk({tag, ".stallreq"}, 70'(stallreq), 70'd1);
    chk({tag, ".addr"},     70'(dbus_if.data_addr), 70'(exp_addr));
    chk({tag, ".we"},       70'(dbus_if.data_we), 70'(exp_we));
    chk({tag, ".be"},       70'(dbus_if.data_be), 70'(exp_be));
    if (exp_we) chk({tag, ".wdata"}, 70'(dbus_if.data_wdata), 70'(exp_wd));
    dbus_if.data_gnt = 1'b1;
    @(negedge clk);
    dbus_if.data_gnt = 1'b0;
    chk({tag, ".wait_req"},      70'(dbus_if.data_req), 70'd0);
    chk({tag, ".wait_stallreq"}, 70'(stallreq), 70'd1);
    chk({tag, ".wait_wb"},       wb_bus, 70'd0);
    dbus_if.data_rvalid = 1'b1;
    dbus_if.data_rdata  = rdata;
    @(negedge clk);
    dbus_if.data_rvalid = 1'b0;
    dbus_if.data_rdata  = '0;
    chk({tag, ".done_stallreq"}, 70'(stallreq), 70'd0);
    chk({tag, ".done_wb"},       wb_bus, exp_wb);
    chk({tag, ".done_err"},      70'(addr_err), 70'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    stall_drv = '0;
    ex_bus = '0;
    dbus_if.data_gnt = 1'b0;
    dbus_if.data_rvalid = 1'b0;
    dbus_if.data_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset.wb",       wb_bus, 70'd0);
    chk("reset.req",      70'(dbus_if.data_req), 70'd0);
    chk("reset.stallreq", 70'(stallreq), 70'd0);
    chk("reset.err",      70'(addr_err), 70'd0);
    rst = 1'b1;
    @(negedge clk);

    access("lw",  mk(32'h100, 4'd5, 1'b1, 5'd5, 32'h1004, 32'h0), 0, 32'hDEADBEEF,
           32'h1004, 1'b0, 4'b1111, 32'h0, wbv(32'h100, 1'b1, 5'd5, 32'hDEADBEEF));
    access("lb",  mk(32'h104, 4'd1, 1'b1, 5'd6, 32'h2003, 32'h0), 0, 32'h80123456,
           32'h2000, 1'b0, 4'b1111, 32'h0, wbv(32'h104, 1'b1, 5'd6, 32'hFFFFFF80));
    access("lbu", mk(32'h108, 4'd2, 1'b1, 5'd7, 32'h2003, 32'h0), 0, 32'h80123456,
           32'h2000, 1'b0, 4'b1111, 32'h0, wbv(32'h108, 1'b1, 5'd7, 32'h00000080));
    access("lhu", mk(32'h10C, 4'd4, 1'b1, 5'd8, 32'h2002, 32'h0), 0, 32'h80123456,
           32'h2000, 1'b0, 4'b1111, 32'h0, wbv(32'h10C, 1'b1, 5'd8, 32'h00008012));
    access("lh",  mk(32'h110, 4'd3, 1'b1, 5'd10, 32'h2002, 32'h0), 1, 32'h80123456,
           32'h2000, 1'b0, 4'b1111, 32'h0, wbv(32'h110, 1'b1, 5'd10, 32'hFFFF8012));
    access("sb",  mk(32'h114, 4'd6, 1'b1, 5'd11, 32'h3002, 32'h000000A5), 3, 32'h0,
           32'h3000, 1'b1, 4'b0100, 32'hA5A5A5A5, wbv(32'h114, 1'b0, 5'd11, 32'h3002));
    access("sh",  mk(32'h118, 4'd7, 1'b1, 5'd12, 32'h3002, 32'h1234BEEF), 1, 32'h0,
           32'h3000, 1'b1, 4'b1100, 32'hBEEFBEEF, wbv(32'h118, 1'b0, 5'd12, 32'h3002));
    access("sw",  mk(32'h11C, 4'd8, 1'b1, 5'd13, 32'h3000, 32'hCAFEF00D), 0, 32'h0,
           32'h3000, 1'b1, 4'b1111, 32'hCAFEF00D, wbv(32'h11C, 1'b0, 5'd13, 32'h3000));

    // Later-stage stall in DONE holds the result, then MEM-only stall bubbles.
    stall_drv = 6'b011000;
    ex_bus = mk(32'h120, 4'd0, 1'b1, 5'd14, 32'h99, 32'h0);
    @(negedge clk);
    chk("hold.wb1", wb_bus, wbv(32'h11C, 1'b0, 5'd13, 32'h3000));
    @(negedge clk);
    chk("hold.wb2", wb_bus, wbv(32'h11C, 1'b0, 5'd13, 32'h3000));
    stall_drv = 6'b001000;
    @(negedge clk);
    chk("bubble.wb",       wb_bus, 70'd0);
    chk("bubble.stallreq", 70'(stallreq), 70'd0);

    // Non-memory ops pass ex_result through with no bus activity.
    stall_drv = '0;
    ex_bus = mk(32'h200, 4'd0, 1'b1, 5'd9, 32'd7, 32'h0);
    @(negedge clk);
    chk("add.req", 70'(dbus_if.data_req), 70'd0);
    chk("add.stallreq", 70'(stallreq), 70'd0);
    chk("add.wb", wb_bus, wbv(32'h200, 1'b1, 5'd9, 32'd7));
    ex_bus = mk(32'h204, 4'd9, 1'b1, 5'd3, 32'h55, 32'h0);
    @(negedge clk);
    chk("op9.req", 70'(dbus_if.data_req), 70'd0);
    chk("op9.wb", wb_bus, wbv(32'h204, 1'b1, 5'd3, 32'h55));

    // Asynchronous reset while waiting for the response.
    ex_bus = mk(32'h300, 4'd5, 1'b1, 5'd4, 32'h4000, 32'h0);
    dbus_if.data_gnt = 1'b1;
    @(negedge clk);
    ex_bus = '0;
    @(negedge clk);
    dbus_if.data_gnt = 1'b0;
    chk("rstwait.pre_stallreq", 70'(stallreq), 70'd1);
    rst = 1'b0;
    #1;
    chk("rstwait.stallreq", 70'(stallreq), 70'd0);
    chk("rstwait.req", 70'(dbus_if.data_req), 70'd0);
    chk("rstwait.wb", wb_bus, 70'd0);
    @(negedge clk);
    rst = 1'b1;
    dbus_if.data_rvalid = 1'b1;
    dbus_if.data_rdata = 32'h12345678;
    @(negedge clk);
    dbus_if.data_rvalid = 1'b0;
    dbus_if.data_rdata = '0;
    chk("late_rvalid.stallreq", 70'(stallreq), 70'd0);
    chk("late_rvalid.wb", wb_bus, 70'd0);
    access("lw2", mk(32'h304, 4'd5, 1'b1, 5'd4, 32'h4000, 32'h0), 0, 32'h0BADF00D,
           32'h4000, 1'b0, 4'b1111, 32'h0, wbv(32'h304, 1'b1, 5'd4, 32'h0BADF00D));

    // Asynchronous reset while a store request is pending.
    ex_bus = mk(32'h308, 4'd8, 1'b1, 5'd1, 32'h5000, 32'hFFFFFFFF);
    @(negedge clk);
    ex_bus = '0;
    chk("rstreq.pre_req", 70'(dbus_if.data_req), 70'd1);
    rst = 1'b0;
    #1;
    chk("rstreq.req", 70'(dbus_if.data_req), 70'd0);
    chk("rstreq.we", 70'(dbus_if.data_we), 70'd0);
    chk("rstreq.be", 70'(dbus_if.data_be), 70'd0);
    chk("rstreq.wdata", 70'(dbus_if.data_wdata), 70'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef MEM_ALIGN_CHECK_EN
    ex_bus = mk(32'h400, 4'd5, 1'b1, 5'd2, 32'h2002, 32'h0);
    @(negedge clk);
    ex_bus = '0;
    chk("align.req", 70'(dbus_if.data_req), 70'd0);
    chk("align.stallreq", 70'(stallreq), 70'd0);
    chk("align.err", 70'(addr_err), 70'd1);
    chk("align.rf_we", 70'(wb_bus[37]), 70'd0);
`else
    access("lw_mis", mk(32'h400, 4'd5, 1'b1, 5'd2, 32'h2002, 32'h0), 0, 32'h11223344,
           32'h2000, 1'b0, 4'b1111, 32'h0, wbv(32'h400, 1'b1, 5'd2, 32'h11223344));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage of the 5-stage MIPS core, between EX and WB.
- Registers the EX result bundle and performs loads/stores on a request/grant/response data bus.
- Stalls the pipeline while an access is outstanding.
- Produces the 70-bit mem_to_wb_bus consumed by the WB stage, with load data aligned and extended.

Parameters:
- STALL_W, 6, width of the pipeline stall vector.
- STAGE_IDX, 3, index of this stage's bit in stall; bit STAGE_IDX+1 belongs to WB.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  STALL_W  pipeline stall vector; 1 = Stop.
- ex_to_mem_bus  in  106  {pc[31:0], mem_op[3:0], rf_we, rf_waddr[4:0], ex_result[31:0], store_data[31:0]}.
- mem_to_wb_bus  out  70  {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- stallreq_for_mem  out  1  request to the stall controller to freeze IF..MEM.
- data_req  out  1  access request, held until granted.
- data_we  out  1  1 = store.
- data_be  out  4  byte enables.
- data_addr  out  32  word-aligned address.
- data_wdata  out  32  store data, replicated per lane.
- data_gnt  in  1  request accepted this cycle.
- data_rvalid  in  1  response valid (loads and stores both respond); at most one outstanding.
- data_rdata  in  32  load data.
- mem_addr_err  out  1  misaligned-access flag (optional feature).

Behaviour:
- mem_op encoding: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
- Reset (rst=0, asynchronous):
  - Entry register, FSM state and hold register clear to 0/IDLE.
  - All outputs are 0, including while a request is pending mid-handshake.
- Entry register, priority order:
  - If stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0: load all-zero bubble.
  - Else if stall[STAGE_IDX]=0: capture ex_to_mem_bus.
  - Else hold.
- FSM states: IDLE, REQ, WAIT, DONE.
  - On any capture: next state is REQ if the captured mem_op is 1-8, else IDLE.
  - REQ: data_req=1. Stay until data_gnt=1, then go to WAIT.
  - WAIT: stay until data_rvalid=1, then go to DONE and latch data_rdata into the hold register.
  - DONE and IDLE: hold until the next capture.
- data_gnt and data_rvalid are ignored outside REQ and WAIT respectively.
- stallreq_for_mem = (state==REQ) | (state==WAIT), combinational.
- While stallreq_for_mem=1, mem_to_wb_bus is all zero, so WB sees bubbles and the debug trace never duplicates.
- Minimum load/store latency is 3 cycles from capture to result:
  - cycle 1: REQ with gnt.
  - cycle 2: WAIT with rvalid.
  - cycle 3: DONE, output valid, stall released.
- Request fields, constant while in REQ:
  - data_addr = {ex_result[31:2], 2'b00}.
  - data_we = 1 for SB/SH/SW, else 0.
- Store lanes:
  - SB: be = 4'b0001 << ex_result[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: be = ex_result[1] ? 4'b1100 : 4'b0011; wdata = {2{store_data[15:0]}}.
  - SW: be = 4'b1111; wdata = store_data.
- Loads: be = 4'b1111.
- rf_wdata by op:
  - Non-memory op: ex_result.
  - Stores: ex_result, with rf_we forced 0.
  - LB/LBU: byte ex_result[1:0] of the hold register, sign-/zero-extended.
  - LH/LHU: half ex_result[1] of the hold register, sign-/zero-extended.
  - LW: the hold register.
- Output pc, rf_we and rf_waddr come from the entry register.
- Stall from a later stage (stall[STAGE_IDX] and stall[STAGE_IDX+1] both 1) with state DONE: the entry and hold register are held, and output is stable.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Enabled:
  - A misaligned access is never issued: LH/LHU/SH with ex_result[0]=1, or LW/SW with ex_result[1:0]!=0.
  - On capture of such an op, the FSM goes directly to DONE.
  - While the entry is in DONE: rf_we output forced 0 and mem_addr_err=1.
- Disabled:
  - mem_addr_err is tied to 0.
  - Misaligned accesses are issued using the lane rules above (the address low bits select lanes only).

Test Plan:
- LW at 0x0000_1004, rf_waddr=5, gnt immediate, rvalid next cycle, rdata=0xDEAD_BEEF -> stallreq high for 2 cycles; then mem_to_wb_bus={pc,1,5,0xDEADBEEF}; stallreq low.
- LB at 0x...03, rdata=0x8012_3456 -> rf_wdata=0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LHU at 0x...02 -> 0x0000_8012.
- SB at 0x...02, store_data=0x0000_00A5, gnt delayed 3 cycles -> data_req held 4 cycles; data_be=4'b0100; data_wdata=0xA5A5_A5A5; rf_we=0 at output.
- ADD result passthrough (mem_op=0, ex_result=7, rf_waddr=9) -> no data_req; output {pc,1,9,7} the cycle after capture.
- rst driven low while in WAIT -> data_req and stallreq drop immediately, outputs 0; a late rvalid after reset is ignored.
- With MEM_ALIGN_CHECK_EN, LW at 0x...02 -> no data_req; mem_addr_err=1; rf_we=0 the cycle after capture.
